// File: rtl/d_latch_driver.sv
// d_latch_driver: conditions raw switch/button inputs and drives a D latch bank.
// It synchronises and debounces SW_D/BTN_E, then turns each debounced button
// press into a setup/strobe/hold sequence on E/D. At the end of the sequence
// it compares the latch Q/QNOT feedback against D and reports the result on ERR.
module d_latch_driver #(
  parameter int WIDTH         = 1,
  parameter int DB_CYCLES     = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW_D,
  input  logic             BTN_E,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] QNOT,
  output logic             E,
  output logic [WIDTH-1:0] D,
  output logic             BUSY,
  output logic             ERR
);

  // The switches and the button share one conditioning path; the button is the top bit.
  localparam int NB   = WIDTH + 1;
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // The phase counter is wide enough for the longest of the three windows.
  localparam int PH_MAX = (SETUP_CYCLES > STROBE_CYCLES) ?
                          ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                          ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = $clog2(PH_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_db;
  logic [DB_W-1:0]  r_db_cnt [NB];
  logic             r_btn_prev;

  logic [WIDTH-1:0] w_db_sw;
  logic             w_db_btn;
  logic             w_req;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_e;
  logic             w_e_nxt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_d_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_err;
  logic             w_err_nxt;

  assign w_raw = {BTN_E, SW_D};

  // Two-flop synchroniser on every raw input bit.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debouncer: a change is accepted only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge CLK) begin
    // NOTE: this counter array is a handful of flops, not a RAM, so it is cleared on reset like any register.
    if (RST) begin
      r_db <= '0;
      for (int i = 0; i < NB; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Previous debounced button value, used to turn a level into a one-cycle request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_prev <= w_db_btn;
    end
  end

  assign w_db_sw  = r_db[WIDTH-1:0];
  assign w_db_btn = r_db[WIDTH];
  assign w_req    = w_db_btn & ~r_btn_prev;

  // Sequencer state and all outputs live in registers so nothing combinational reaches a port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= w_e_nxt;
      r_d     <= w_d_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic: walks IDLE -> SETUP -> STROBE -> HOLD and computes the registered outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_e_nxt     = 1'b0;
    w_d_nxt     = r_d;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_req) begin
          // D is captured only here; switch movement during a sequence is ignored.
          w_d_nxt     = w_db_sw;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_cnt_nxt   = '0;
          w_e_nxt     = 1'b1;
          w_state_nxt = S_STROBE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_e_nxt   = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          // Requests arriving on this edge see a non-IDLE state and are dropped.
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = (Q != r_d) | (QNOT != ~r_d);
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign E    = r_e;
  assign D    = r_d;
  assign BUSY = r_busy;
  assign ERR  = r_err;

endmodule

// File: tb/tb_d_latch_driver.sv
// Testbench for d_latch_driver: directed steps with a scoreboard queue of expected values.
module tb_d_latch_driver;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  // Timing of the WIDTH=4 / DB_CYCLES=1 instance, counted in edges after the button rise.
  localparam int DB4        = 1;
  localparam int REQ_EDGE4  = 2 + DB4 + 1;
  localparam int E_FIRST4   = REQ_EDGE4 + 2;
  localparam int E_LAST4    = E_FIRST4 + 3 - 1;
  localparam int BUSY_LAST4 = REQ_EDGE4 + 7 - 1;

  logic       clk;
  logic       rst;
  logic       force_q0;

  logic       sw1, btn1, q1, qnot1, e1, d1, busy1, err1;
  logic [3:0] sw4, q4, qnot4, d4;
  logic       btn4, e4, busy4, err4;

  exp_t sb[$];
  int   checks;
  int   errors;

  d_latch_driver u_dut1 (
    .CLK  (clk),
    .RST  (rst),
    .SW_D (sw1),
    .BTN_E(btn1),
    .Q    (q1),
    .QNOT (qnot1),
    .E    (e1),
    .D    (d1),
    .BUSY (busy1),
    .ERR  (err1)
  );

  d_latch_driver #(.WIDTH(4), .DB_CYCLES(DB4)) u_dut4 (
    .CLK  (clk),
    .RST  (rst),
    .SW_D (sw4),
    .BTN_E(btn4),
    .Q    (q4),
    .QNOT (qnot4),
    .E    (e4),
    .D    (d4),
    .BUSY (busy4),
    .ERR  (err4)
  );

  // Latch bank models: u_dut4 always echoes correctly, u_dut1 can have Q stuck at 0.
  assign q1    = force_q0 ? 1'b0 : d1;
  assign qnot1 = ~d1;
  assign q4    = d4;
  assign qnot4 = ~d4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [3:0] val);
    exp_t x;
    x.tag = tag;
    x.val = val;
    sb.push_back(x);
  endtask

  task automatic check(input logic [3:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %0h expected none", obs);
      return;
    end
    x = sb.pop_front();
    assert (obs === x.val) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.val);
    end
  endtask

  initial begin
    logic seen_e, seen_busy, seen_d;
    int   e_cnt;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    force_q0 = 1'b0;
    sw1      = 1'b0;
    btn1     = 1'b0;
    sw4      = 4'b0000;
    btn4     = 1'b0;

    // Reset state of both instances.
    tick(2);
    expect_v("rst_e", 4'd0);
    expect_v("rst_d", 4'd0);
    expect_v("rst_busy", 4'd0);
    expect_v("rst_err", 4'd0);
    expect_v("rst_e4", 4'd0);
    expect_v("rst_d4", 4'd0);
    check(4'(e1));
    check(4'(d1));
    check(4'(busy1));
    check(4'(err1));
    check(4'(e4));
    check(d4);
    rst = 1'b0;
    tick(1);

    // Button glitch shorter than the debounce window must not start a sequence.
    sw1  = 1'b1;
    btn1 = 1'b1;
    tick(3);
    btn1      = 1'b0;
    seen_e    = 1'b0;
    seen_busy = 1'b0;
    seen_d    = 1'b0;
    expect_v("glitch_e", 4'd0);
    expect_v("glitch_busy", 4'd0);
    expect_v("glitch_d", 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen_e    = seen_e | e1;
      seen_busy = seen_busy | busy1;
      seen_d    = seen_d | d1;
    end
    check(4'(seen_e));
    check(4'(seen_busy));
    check(4'(seen_d));

    // Held press: latency, strobe width, busy span; switch moved mid-strobe.
    btn1 = 1'b1;
    expect_v("lat_busy_e6", 4'd0);
    expect_v("lat_busy_e7", 4'd1);
    expect_v("lat_d_e7", 4'd1);
    expect_v("lat_e_e8", 4'd0);
    expect_v("lat_e_e9", 4'd1);
    expect_v("strobe_e_e11", 4'd1);
    expect_v("mid_d_e11", 4'd1);
    expect_v("strobe_e_e12", 4'd0);
    expect_v("hold_busy_e13", 4'd1);
    expect_v("end_busy_e14", 4'd0);
    expect_v("end_err_e14", 4'd0);
    expect_v("end_d_e14", 4'd1);
    tick(6);  check(4'(busy1));
    tick(1);  check(4'(busy1)); check(4'(d1));
    tick(1);  check(4'(e1));
    tick(1);  check(4'(e1));
    sw1 = 1'b0;
    tick(2);  check(4'(e1)); check(4'(d1));
    tick(1);  check(4'(e1));
    tick(1);  check(4'(busy1));
    tick(1);  check(4'(busy1)); check(4'(err1)); check(4'(d1));

    // Idle: D holds its value while the switch settles back to 1.
    sw1  = 1'b1;
    btn1 = 1'b0;
    expect_v("idle_d", 4'd1);
    tick(10);
    check(4'(d1));

    // Faulty feedback (Q stuck at 0 with D=1) flags ERR at sequence end.
    force_q0 = 1'b1;
    btn1     = 1'b1;
    expect_v("err_busy_e13", 4'd1);
    expect_v("err_old_e13", 4'd0);
    expect_v("err_set_e14", 4'd1);
    expect_v("err_busy_e14", 4'd0);
    tick(13); check(4'(busy1)); check(4'(err1));
    tick(1);  check(4'(err1));  check(4'(busy1));

    // ERR holds with feedback repaired and no new sequence.
    force_q0 = 1'b0;
    btn1     = 1'b0;
    expect_v("err_held", 4'd1);
    tick(10);
    check(4'(err1));

    // Reset on the second strobe cycle clears everything at that edge.
    btn1 = 1'b1;
    expect_v("pre_rst_e", 4'd1);
    expect_v("mid_rst_e", 4'd0);
    expect_v("mid_rst_busy", 4'd0);
    expect_v("mid_rst_d", 4'd0);
    expect_v("mid_rst_err", 4'd0);
    tick(10);
    check(4'(e1));
    rst  = 1'b1;
    btn1 = 1'b0;
    tick(1);
    check(4'(e1));
    check(4'(busy1));
    check(4'(d1));
    check(4'(err1));
    rst = 1'b0;
    tick(2);

    // A fresh press after reset runs a full sequence.
    btn1 = 1'b1;
    expect_v("re_e_e8", 4'd0);
    expect_v("re_e_e9", 4'd1);
    expect_v("re_d_e9", 4'd1);
    expect_v("re_busy_e14", 4'd0);
    expect_v("re_err_e14", 4'd0);
    tick(8); check(4'(e1));
    tick(1); check(4'(e1)); check(4'(d1));
    tick(5); check(4'(busy1)); check(4'(err1));

    // WIDTH=4: pattern 1010 held through the sequence; a second press and a switch
    // change during STROBE land on the busy-clearing edge and are both ignored.
    sw4  = 4'b1010;
    btn4 = 1'b1;
    tick(1);
    btn4 = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      expect_v($sformatf("w4_e_%0d", k), 4'((k >= E_FIRST4) && (k <= E_LAST4)));
      expect_v($sformatf("w4_busy_%0d", k), 4'((k >= REQ_EDGE4) && (k <= BUSY_LAST4)));
      expect_v($sformatf("w4_d_%0d", k), (k >= REQ_EDGE4) ? 4'b1010 : 4'b0000);
    end
    expect_v("w4_err", 4'd0);
    expect_v("w4_e_cycles", 4'd3);
    e_cnt = 0;
    for (int k = 2; k <= 20; k++) begin
      tick(1);
      check(4'(e4));
      check(4'(busy4));
      check(d4);
      if (e4) e_cnt++;
      if (k == 7) begin
        sw4  = 4'b0101;
        btn4 = 1'b1;
      end
    end
    check(4'(err4));
    check(4'(e_cnt));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_latch_driver.md
Name: d_latch_driver

Overview:
- Upstream stimulus stage for the D latch bank: synchronises and debounces raw switch/button inputs, then issues a clean enable strobe with data held stable across setup, strobe and hold windows.
- Checks latch outputs Q/QNOT after each strobe and flags mismatches.
- Sits between the board switches/buttons and the latch E/D inputs.

Parameters:
- WIDTH, 1, data bits driven (latch bank width).
- DB_CYCLES, 4, consecutive stable samples required to accept a raw input change (>=1).
- SETUP_CYCLES, 2, cycles D is held before E rises (>=1).
- STROBE_CYCLES, 3, cycles E is high (>=1).
- HOLD_CYCLES, 2, cycles D is held after E falls (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- SW_D  input  WIDTH  raw data switches, asynchronous.
- BTN_E  input  1  raw strobe request button, asynchronous.
- Q  input  WIDTH  latch bank Q feedback.
- QNOT  input  WIDTH  latch bank QNOT feedback.
- E  output  1  latch enable strobe.
- D  output  WIDTH  latch data.
- BUSY  output  1  high while a strobe sequence is in progress.
- ERR  output  1  result of the last sequence's check; 1 = mismatch.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). On RST: E=0, D=0, BUSY=0, ERR=0, FSM=IDLE, sync/debounce flops=0, all counters=0. Reset mid-sequence: E drops at that same edge; no check performed.
- Sync: two-flop synchroniser per bit of SW_D and BTN_E.
- Debounce (per bit): if sync != debounced, counter++. When DB_CYCLES consecutive differing samples are seen, debounced <= sync and counter clears. Any sample equal to debounced clears the counter. Glitches shorter than DB_CYCLES never propagate.
- Request: rising edge of debounced BTN (registered previous value).
- FSM states:
  - IDLE: E=0, BUSY=0. On request: D <= debounced SW, BUSY <= 1, go SETUP.
  - SETUP: E=0 for SETUP_CYCLES cycles, then STROBE.
  - STROBE: E=1 for exactly STROBE_CYCLES cycles, then HOLD.
  - HOLD: E=0 for HOLD_CYCLES cycles. On the final HOLD edge: ERR <= (Q != D) | (QNOT != ~D); BUSY <= 0; go IDLE.
- D changes only on IDLE->SETUP. Switch changes during a sequence do not affect D.
- Requests arriving while BUSY are dropped, not queued. A request on the same edge BUSY clears is also dropped; it is accepted from IDLE the next cycle only if it is a fresh edge.
- ERR holds its value until the next completed sequence or reset.
- Latency: a stable BTN_E rise reaches E=1 after 2 + DB_CYCLES + 1 + SETUP_CYCLES edges (9 with defaults). BUSY spans SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles (7 with defaults).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, SW_D=1, BTN_E held high -> E rises 9 edges after the BTN_E rise, stays high 3 cycles; D=1 from cycle 7 until the next request; BUSY high 7 cycles.
- BTN_E pulses high for 3 cycles (< DB_CYCLES) -> E, D, BUSY remain 0.
- Sequence running, SW_D toggled and BTN_E pressed again mid-STROBE -> D unchanged, exactly one 3-cycle E pulse, second press ignored.
- Model latch fed back correctly (Q=D, QNOT=~D) -> ERR=0. Then Q forced to 0 with D=1 -> ERR=1 at sequence end, held until the next sequence.
- RST asserted on the 2nd STROBE cycle -> E=0, BUSY=0, D=0, ERR=0 after that edge; a new press after release produces a full sequence.
- WIDTH=4, SW_D=4'b1010 -> D=4'b1010 for the whole sequence; ERR=0 with a matching feedback model.
